// File: rtl/game_controller.sv
// Game flow controller: start screen, timed round, win screens with a
// minimum display hold. All screen changes are aligned to frame edges.

package vga_pkg;
    typedef enum logic [1:0] {
        START    = 2'd0,
        GAME     = 2'd1,
        PLAYER_1 = 2'd2,
        PLAYER_2 = 2'd3
    } screen_t;
endpackage

module game_controller
    import vga_pkg::*;
#(
    parameter int WIN_POINTS   = 10,
    parameter int ROUND_FRAMES = 3600,
    parameter int HOLD_FRAMES  = 300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        vblnk,
    input  logic [4:0]  points_p1,
    input  logic [4:0]  points_p2,
    output logic [1:0]  screen,
    output logic        game_rst,
    output logic [11:0] frames_left
);

    localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
    localparam logic [5:0] WIN = 6'(WIN_POINTS);

    screen_t       state;
    logic [HW-1:0] hold_cnt;
    logic          pending;
    logic          vblnk_q;
    logic          start_q;
    logic          after_rst;   // masks a start level that was already high at reset release
    logic          frame_edge;
    logic          start_edge;
    logic          p1_hit, p2_hit, p1_ahead, p2_ahead;
    screen_t       verdict;

    assign frame_edge = vblnk & ~vblnk_q;
    assign start_edge = start & ~start_q & ~after_rst;
    assign screen     = state;

    // Round outcome from the scores presented at this frame edge
    always_comb begin
        p1_hit   = ({1'b0, points_p1} >= WIN);
        p2_hit   = ({1'b0, points_p2} >= WIN);
        p1_ahead = (points_p1 > points_p2);
        p2_ahead = (points_p2 > points_p1);
        verdict  = GAME;
        if (p1_hit && p2_hit) begin
            if (p1_ahead)      verdict = PLAYER_1;
            else if (p2_ahead) verdict = PLAYER_2;
        end else if (p1_hit) begin
            verdict = PLAYER_1;
        end else if (p2_hit) begin
            verdict = PLAYER_2;
        end else if (frames_left == 12'd0) begin
            // time up: leader wins, a tie plays on as sudden death
            if (p1_ahead)      verdict = PLAYER_1;
            else if (p2_ahead) verdict = PLAYER_2;
        end
    end

    // Screen FSM with edge detectors, round timer, hold counter and reset pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= START;
            game_rst    <= 1'b0;
            frames_left <= 12'd0;
            hold_cnt    <= '0;
            pending     <= 1'b0;
            vblnk_q     <= 1'b0;
            start_q     <= 1'b0;
            after_rst   <= 1'b1;
        end else begin
            vblnk_q   <= vblnk;
            start_q   <= start;
            after_rst <= 1'b0;
            game_rst  <= 1'b0;
            case (state)
                START: begin
                    if (frame_edge && pending) begin
                        state       <= GAME;
                        game_rst    <= 1'b1;
                        frames_left <= 12'(ROUND_FRAMES);
                        pending     <= 1'b0;
                    end else if (start_edge) begin
                        pending <= 1'b1;
                    end
                end
                GAME: begin
                    pending <= 1'b0;
                    if (frame_edge) begin
                        if (frames_left != 12'd0)
                            frames_left <= frames_left - 12'd1;
                        state <= verdict;
                        if (verdict != GAME)
                            hold_cnt <= HW'(HOLD_FRAMES);
                    end
                end
                default: begin
                    if (frame_edge && pending) begin
                        state       <= START;
                        game_rst    <= 1'b1;
                        pending     <= 1'b0;
                        frames_left <= 12'd0;
                    end else begin
                        if (frame_edge && hold_cnt != '0)
                            hold_cnt <= hold_cnt - 1'b1;
                        if (start_edge && hold_cnt == '0)
                            pending <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: two instances (default round, short round),
// a spec-level model checked every cycle, plus directed literal checks.

module tb_game_controller;
    import vga_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        vblnk = 1'b0;
    logic [4:0]  p1 = 5'd0;
    logic [4:0]  p2 = 5'd0;
    logic [1:0]  scr_a, scr_b;
    logic        grst_a, grst_b;
    logic [11:0] fl_a, fl_b;

    int compared = 0;
    int mismatched = 0;

    game_controller #(.WIN_POINTS(10), .ROUND_FRAMES(3600), .HOLD_FRAMES(300)) dut_a (
        .clk(clk), .rst(rst), .start(start), .vblnk(vblnk),
        .points_p1(p1), .points_p2(p2),
        .screen(scr_a), .game_rst(grst_a), .frames_left(fl_a)
    );

    game_controller #(.WIN_POINTS(10), .ROUND_FRAMES(5), .HOLD_FRAMES(3)) dut_b (
        .clk(clk), .rst(rst), .start(start), .vblnk(vblnk),
        .points_p1(p1), .points_p2(p2),
        .screen(scr_b), .game_rst(grst_b), .frames_left(fl_b)
    );

    always #5 clk = ~clk;

    // 8-cycle frames, vblnk high for the first 2 cycles of each
    initial begin
        int vcnt;
        vcnt = 7;
        forever begin
            @(posedge clk);
            #1;
            vcnt = (vcnt + 1) % 8;
            vblnk = (vcnt < 2);
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        int scr;     // 0 START, 1 GAME, 2 PLAYER_1, 3 PLAYER_2
        int frames;
        int hold;
        bit pend;
        bit grst;
        bit vq;
        bit sq;
        bit first;
    } mst_t;

    // 0: no winner yet, 1: player 1, 2: player 2
    function automatic int judge(int a, int b, bit timeout);
        if (a >= 10 && b >= 10) return (a > b) ? 1 : (b > a) ? 2 : 0;
        if (a >= 10) return 1;
        if (b >= 10) return 2;
        if (timeout) return (a > b) ? 1 : (b > a) ? 2 : 0;
        return 0;
    endfunction

    function automatic mst_t mstep(mst_t m, logic r, logic st, logic vb,
                                   logic [4:0] a, logic [4:0] b, int rf, int hf);
        mst_t n;
        bit fe, se;
        int w;
        n = '{default: 0};
        if (r) begin
            n.first = 1'b1;
            return n;
        end
        n = m;
        n.grst = 1'b0;
        n.vq = vb;
        n.sq = st;
        n.first = 1'b0;
        fe = vb && !m.vq;
        se = st && !m.sq && !m.first;
        if (m.scr == 0) begin
            if (fe && m.pend) begin
                n.scr = 1; n.grst = 1'b1; n.frames = rf; n.pend = 1'b0;
            end else if (se) n.pend = 1'b1;
        end else if (m.scr == 1) begin
            n.pend = 1'b0;
            if (fe) begin
                w = judge(int'(a), int'(b), m.frames == 0);
                n.frames = (m.frames > 0) ? m.frames - 1 : 0;
                if (w != 0) begin
                    n.scr = w + 1;
                    n.hold = hf;
                end
            end
        end else begin
            if (fe && m.pend) begin
                n.scr = 0; n.grst = 1'b1; n.pend = 1'b0; n.frames = 0;
            end else begin
                if (fe && m.hold > 0) n.hold = m.hold - 1;
                if (se && m.hold == 0) n.pend = 1'b1;
            end
        end
        return n;
    endfunction

    mst_t ma, mb;
    bit   mvalid = 1'b0;

    always @(posedge clk) begin
        ma <= mstep(ma, rst, start, vblnk, p1, p2, 3600, 300);
        mb <= mstep(mb, rst, start, vblnk, p1, p2, 5, 3);
        mvalid <= 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle model comparison
    always @(negedge clk) begin
        if (mvalid) begin
            chk("a_screen", int'(scr_a), ma.scr);
            chk("a_game_rst", int'(grst_a), int'(ma.grst));
            chk("a_frames_left", int'(fl_a), ma.frames);
            chk("b_screen", int'(scr_b), mb.scr);
            chk("b_game_rst", int'(grst_b), int'(mb.grst));
            chk("b_frames_left", int'(fl_b), mb.frames);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse_start_mid();
        @(negedge vblnk);
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // returns #1 after the clock edge at which the DUT saw the frame edge
    task automatic frame_edge_wait();
        @(posedge vblnk);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n);
        repeat (n) frame_edge_wait();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("lit_reset_screen", int'(scr_a), 0);
        chk("lit_reset_frames", int'(fl_a), 0);
        chk("lit_reset_game_rst", int'(grst_a), 0);

        // start mid-frame: wait for next vblnk rise
        pulse_start_mid();
        chk("lit_start_wait_screen", int'(scr_a), 0);
        @(posedge vblnk);
        chk("lit_before_edge_screen", int'(scr_a), 0);
        @(posedge clk);
        #1;
        chk("lit_enter_game_screen", int'(scr_a), 1);
        chk("lit_enter_game_rst", int'(grst_a), 1);
        chk("lit_enter_game_frames", int'(fl_a), 3600);
        @(posedge clk);
        #1;
        chk("lit_game_rst_one_cycle", int'(grst_a), 0);

        // player 1 reaches the win score
        p1 = 5'd10; p2 = 5'd4;
        frame_edge_wait();
        chk("lit_p1_wins", int'(scr_a), 2);
        p1 = 5'd0; p2 = 5'd0;
        wait_frames(2);
        pulse_start_mid();
        wait_frames(2);
        chk("lit_hold_ignores_start", int'(scr_a), 2);
        wait_frames(300);
        pulse_start_mid();
        frame_edge_wait();
        chk("lit_back_to_start", int'(scr_a), 0);
        chk("lit_back_to_start_rst", int'(grst_a), 1);

        // simultaneous tie at the win score, then player 2 pulls ahead
        pulse_start_mid();
        frame_edge_wait();
        chk("lit_game_again", int'(scr_a), 1);
        p1 = 5'd10; p2 = 5'd10;
        frame_edge_wait();
        chk("lit_tie_keeps_game", int'(scr_a), 1);
        p2 = 5'd11;
        frame_edge_wait();
        chk("lit_p2_wins", int'(scr_a), 3);
        p1 = 5'd0; p2 = 5'd0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("lit_reset_from_win", int'(scr_a), 0);

        // short round timeout with a tied score
        pulse_start_mid();
        frame_edge_wait();
        p1 = 5'd3; p2 = 5'd3;
        wait_frames(5);
        chk("lit_b_frames_zero", int'(fl_b), 0);
        chk("lit_b_still_game", int'(scr_b), 1);
        wait_frames(1);
        chk("lit_b_sudden_death", int'(scr_b), 1);
        p1 = 5'd4;
        frame_edge_wait();
        chk("lit_b_timeout_p1", int'(scr_b), 2);
        chk("lit_a_still_game", int'(scr_a), 1);
        chk("lit_a_frames", int'(fl_a), 3593);

        // start held through reset release, then held through a round
        p1 = 5'd0; p2 = 5'd0;
        rst = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_frames(3);
        chk("lit_held_start_no_edge", int'(scr_a), 0);
        start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        frame_edge_wait();
        chk("lit_held_start_game", int'(scr_a), 1);
        wait_frames(3);
        chk("lit_held_start_stays", int'(scr_a), 1);
        chk("lit_held_frames", int'(fl_a), 3597);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("lit_midgame_rst_screen", int'(scr_a), 0);
        chk("lit_midgame_rst_frames", int'(fl_a), 0);
        rst = 1'b0; start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        mismatched++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
